encap_rule_ctrl: RTL
====================

// Module: encap_rule_ctrl
// PURPOSE
//  Per-packet controller for the head-encapsulation stage. Tracks the tagged head stream and
//  looks up an encap rule (shift/offset/length/field/enable) by rule index at packet start.
//  Re-times the head by one cycle so the rule outputs are valid in the start-slice cycle.
//  Also owns the rule table's config write port and the packet/encap/error counters.
// PARAMETERS
//  RULE_NUM    16  number of rule entries
//  RULE_IDX_W   4  width of rule index; RULE_NUM <= 2**RULE_IDX_W
//  RULE_W      1+4+`ENCAP_WIDTH+`META_SHIFT_WIDTH+2*`HEAD_SHIFT_WIDTH  packed rule width
//    Packing, MSB to LSB: {en, sliceOff[3:0], dataOff, encLen, headShift, encapField}
// PORTS
//  i_clk          in   1                     clock
//  i_rst_n        in   1                     synchronous active-low reset
//  i_head         in   HEAD_WIDTH+TAG_WIDTH  tagged head slice
//  i_ruleIdx      in   RULE_IDX_W            rule index; sampled only when i_head start+valid
//  i_globalEn     in   1                     0 forces o_encapEn=0 for packets starting now
//  o_head         out  HEAD_WIDTH+TAG_WIDTH  i_head delayed 1 cycle
//  o_headShift    out  HEAD_SHIFT_WIDTH      rule headShift
//  o_metaSliceOffset out 4                   rule sliceOff
//  o_metaDataOffset  out HEAD_SHIFT_WIDTH    rule dataOff
//  o_encapLength  out  META_SHIFT_WIDTH      rule encLen
//  o_encapField   out  ENCAP_WIDTH           rule encapField
//  o_encapEn      out  1                     rule en & globalEn & index-in-range
//  i_cfg_wren     in   1                     rule write strobe
//  i_cfg_addr     in   RULE_IDX_W            rule write address
//  i_cfg_data     in   RULE_W                rule write data
//  o_cfg_ack      out  1                     one-cycle ack, 1 cycle after accepted write
//  o_pktCnt       out  32                    packets started (wraps)
//  o_encapCnt     out  32                    packets started with o_encapEn=1 (wraps)
//  o_errCnt       out  16                    protocol errors, saturating at 16'hFFFF
// BEHAVIOUR
//  - Reset: all outputs 0, including o_head tags; table entries 0 (en=0); FSM=IDLE.
//  - Start = i_head[START] & i_head[VALID]. Tail = i_head[TAIL] & i_head[VALID].
//  - Latency: o_head = i_head delayed 1. On start, rule outputs update in the same edge.
//    They are therefore valid while o_head carries the start slice.
//  - Rule outputs hold until the next start; they do not change mid-packet.
//  - If i_ruleIdx >= RULE_NUM: other fields are 0, o_encapEn=0, errCnt++.
//  - FSM IDLE: start&~tail -> INPKT; start&tail (1-slice pkt) -> stay IDLE.
//    Valid slice without start -> errCnt++, the slice is still forwarded.
//  - FSM INPKT: tail&~start -> IDLE.
//    Start -> errCnt++ (missing tail); treat as a new packet (lookup, pktCnt++).
//    Then stay INPKT, or go to IDLE if tail is also set.
//  - Counters: pktCnt++ and encapCnt++ (if encapEn) in the cycle the rule outputs load.
//  - Config: a write occurs every cycle i_cfg_wren=1, with no backpressure. It takes effect next cycle.
//  - Same-cycle write and lookup to the same entry: the lookup returns the OLD entry.
//  - i_cfg_addr >= RULE_NUM: the write is dropped, no ack, errCnt++.
//  - Multiple error sources in one cycle increment errCnt by 1 only.
//  - Mid-operation reset: the FSM returns to IDLE and counters clear.
//    The table is reset to all-zero and must be reprogrammed.
// TESTING
//  1 Write rule 3={en=1,sliceOff=1,dataOff=2,encLen=4,headShift=5,field=F}; pkt start idx=3
//    -> next cycle o_head=start slice, o_headShift=5, o_encapEn=1, pktCnt=1, encapCnt=1.
//  2 Same rule, i_globalEn=0 -> o_encapEn=0, other fields loaded, encapCnt unchanged.
//  3 Write rule 3 to headShift=7 in same cycle as start idx=3 -> outputs show 5.
//    Next packet shows 7.
//  4 Two starts without tail between -> errCnt=1, pktCnt=2, second packet's rule loaded.
//  5 1-slice pkt (start+tail), then a valid slice without start -> FSM IDLE, errCnt=1.
//  6 idx=RULE_NUM -> o_encapEn=0, errCnt=1; cfg_addr=RULE_NUM write -> no o_cfg_ack.
//  7 Reset asserted mid-packet -> all outputs 0 next cycle; rule 3 reads en=0 afterwards.

Source files
------------

// File: rtl/encap_rule_ctrl.sv
// encap_rule_ctrl: retimes the tagged head stream, looks up the encap rule at packet start and keeps counters.
// The tag bits sit at the top of i_head: {valid, start, tail, ...}; the rule table is written through the cfg port.
module encap_rule_ctrl #(
  parameter int RULE_NUM         = 16,
  parameter int RULE_IDX_W       = 4,
  parameter int HEAD_WIDTH       = 64,
  parameter int TAG_WIDTH        = 4,
  parameter int ENCAP_WIDTH      = 16,
  parameter int META_SHIFT_WIDTH = 8,
  parameter int HEAD_SHIFT_WIDTH = 6,
  parameter int VALID_BIT        = HEAD_WIDTH + TAG_WIDTH - 1,
  parameter int START_BIT        = HEAD_WIDTH + TAG_WIDTH - 2,
  parameter int TAIL_BIT         = HEAD_WIDTH + TAG_WIDTH - 3,
  parameter int RULE_W           = 1 + 4 + ENCAP_WIDTH + META_SHIFT_WIDTH + 2*HEAD_SHIFT_WIDTH
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0]  i_head,
  input  logic [RULE_IDX_W-1:0]            i_ruleIdx,
  input  logic                             i_globalEn,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0]  o_head,
  output logic [HEAD_SHIFT_WIDTH-1:0]      o_headShift,
  output logic [3:0]                       o_metaSliceOffset,
  output logic [HEAD_SHIFT_WIDTH-1:0]      o_metaDataOffset,
  output logic [META_SHIFT_WIDTH-1:0]      o_encapLength,
  output logic [ENCAP_WIDTH-1:0]           o_encapField,
  output logic                             o_encapEn,
  input  logic                             i_cfg_wren,
  input  logic [RULE_IDX_W-1:0]            i_cfg_addr,
  input  logic [RULE_W-1:0]                i_cfg_data,
  output logic                             o_cfg_ack,
  output logic [31:0]                      o_pktCnt,
  output logic [31:0]                      o_encapCnt,
  output logic [15:0]                      o_errCnt
);
  localparam int HS_O = ENCAP_WIDTH;
  localparam int EL_O = HS_O + HEAD_SHIFT_WIDTH;
  localparam int DO_O = EL_O + META_SHIFT_WIDTH;
  localparam int SO_O = DO_O + HEAD_SHIFT_WIDTH;
  localparam logic [RULE_IDX_W:0] LIM = (RULE_IDX_W+1)'(RULE_NUM);
  typedef enum logic {IDLE, INPKT} state_t;
  state_t state, state_nx;
  logic [RULE_W-1:0] tbl [RULE_NUM];
  logic [RULE_W-1:0] rule;
  logic valid, start, tail, idx_ok, addr_ok, en_now, err;
  assign valid   = i_head[VALID_BIT];
  assign start   = valid & i_head[START_BIT];
  assign tail    = valid & i_head[TAIL_BIT];
  assign idx_ok  = {1'b0, i_ruleIdx} < LIM;
  assign addr_ok = {1'b0, i_cfg_addr} < LIM;
  // Combinational read ahead of the write edge gives old-data on a same-cycle write/lookup
  assign rule    = idx_ok ? tbl[i_ruleIdx] : '0;
  assign en_now  = rule[RULE_W-1] & i_globalEn;
  always_comb begin
    state_nx = tail ? IDLE : start ? INPKT : state;
    err = (valid & ~start & state == IDLE) | (start & state == INPKT) |
          (start & ~idx_ok) | (i_cfg_wren & ~addr_ok);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RULE_NUM; i++) tbl[i] <= '0;
      o_cfg_ack <= 1'b0;
    end else begin
      if (i_cfg_wren && addr_ok) tbl[i_cfg_addr] <= i_cfg_data;
      o_cfg_ack <= i_cfg_wren & addr_ok;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      o_head            <= '0;
      o_headShift       <= '0;
      o_metaSliceOffset <= '0;
      o_metaDataOffset  <= '0;
      o_encapLength     <= '0;
      o_encapField      <= '0;
      o_encapEn         <= 1'b0;
      o_pktCnt          <= '0;
      o_encapCnt        <= '0;
      o_errCnt          <= '0;
    end else begin
      state  <= state_nx;
      o_head <= i_head;
      if (start) begin
        o_headShift       <= rule[HS_O +: HEAD_SHIFT_WIDTH];
        o_metaSliceOffset <= rule[SO_O +: 4];
        o_metaDataOffset  <= rule[DO_O +: HEAD_SHIFT_WIDTH];
        o_encapLength     <= rule[EL_O +: META_SHIFT_WIDTH];
        o_encapField      <= rule[ENCAP_WIDTH-1:0];
        o_encapEn         <= en_now;
        o_pktCnt          <= o_pktCnt + 32'd1;
        o_encapCnt        <= o_encapCnt + 32'(en_now);
      end
      if (err && o_errCnt != 16'hFFFF) o_errCnt <= o_errCnt + 16'd1;
    end
  end
endmodule
